// File: rtl/msr_pkg.sv
// -----------------------------------------------------------------------------
// msr_pkg
// Shared definitions for the memory stream reader:
//   MSR_AW / MSR_DW   default address and data widths (RAM16K, 16-bit words)
//   MSR_DEPTH         number of words in the default address space (2^MSR_AW)
//   MSR_CW            width of a word count that can express 0..MSR_DEPTH
//   msr_state_t       controller states
//   msr_count_width   count width for an arbitrary address width
// -----------------------------------------------------------------------------
package msr_pkg;

    localparam int MSR_AW    = 14;
    localparam int MSR_DW    = 16;
    localparam int MSR_DEPTH = 2 ** MSR_AW;
    localparam int MSR_CW    = $clog2(MSR_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } msr_state_t;

    // A full sweep covers every address, so the count needs one more bit
    // than the address to hold the value 2^aw itself.
    function automatic int msr_count_width(input int aw);
        return $clog2((2 ** aw) + 1);
    endfunction

endpackage

// File: rtl/msr_out_stage.sv
// -----------------------------------------------------------------------------
// msr_out_stage
// Single-entry output register of the memory stream reader. It owns the
// stream word and its valid flag, and tells the controller when a new word
// may be captured from memory.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   load_en        controller wants to capture a word this cycle
//   load_data      word to capture (memory read data)
//   out_data       registered stream word
//   out_valid      out_data holds a word not yet accepted
//   out_ready      sink accepts the word when out_valid is high
//   capture        a word is written into the register at this edge
//   accept         the current word is handed to the sink at this edge
// -----------------------------------------------------------------------------
module msr_out_stage
    import msr_pkg::*;
#(
    parameter int DW = MSR_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_en,
    input  logic [DW-1:0] load_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          capture,
    output logic          accept
);

    // The register may be refilled whenever it is empty or its word is
    // leaving this same edge, which gives one word per cycle under full flow.
    assign capture = load_en && (!out_valid || out_ready);
    assign accept  = out_valid && out_ready;

    // Data and valid move only on a capture or a handshake; a capture takes
    // priority because it both replaces the outgoing word and keeps valid up.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// -----------------------------------------------------------------------------
// mem_stream_reader
// Read-side bus master for the word-addressed RAM family. A start pulse in
// IDLE latches a base address and a word count; the block then walks the
// range (wrapping at 2^AW), reads each word through the memory's
// combinational read port and emits it on a valid/ready stream. done pulses
// for one cycle after the last word is accepted (or right after a start with
// a zero count).
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start          request a sweep, honoured only in IDLE
//   base, count    first address and number of words (0..2^AW)
//   mem_address    address to the memory read port
//   mem_out        memory read data for mem_address
//   out_data       stream word
//   out_valid      out_data holds a word
//   out_ready      sink accepts the word
//   busy           sweep in progress (RUN or DRAIN)
//   done           one-cycle completion pulse
//   checksum       wrapping sum of accepted words (MSR_CHECKSUM_EN only)
//
// Build option: define MSR_CHECKSUM_EN to add the checksum port and adder.
// -----------------------------------------------------------------------------
module mem_stream_reader
    import msr_pkg::*;
#(
    parameter int AW = MSR_AW,
    parameter int DW = MSR_DW
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [AW-1:0]                     base,
    input  logic [msr_count_width(AW)-1:0]    count,
    output logic [AW-1:0]                     mem_address,
    input  logic [DW-1:0]                     mem_out,
    output logic [DW-1:0]                     out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              done
`ifdef MSR_CHECKSUM_EN
    ,
    output logic [DW-1:0]                     checksum
`endif
);

    localparam int CW = msr_count_width(AW);

    msr_state_t    state;
    msr_state_t    state_next;
    logic [AW-1:0] ptr;
    logic [CW-1:0] remaining;
    logic          start_ok;
    logic          capture;
    logic          accept;
    logic          last_capture;

    assign start_ok     = (state == IDLE) && start;
    assign last_capture = capture && (remaining == CW'(1));
    assign busy         = (state != IDLE);

    // The pointer is not advanced past the final word of a sweep, so the
    // read port keeps showing the last address it actually drove.
    assign mem_address  = ptr;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a zero-count start never leaves IDLE, RUN ends on the
    // capture of the last word, DRAIN ends when that word is accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (count != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_capture) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep bookkeeping: the range is latched on an accepted start and then
    // consumed one word per capture. done is registered so it appears the
    // cycle after the completing edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr       <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= (start_ok && (count == '0)) || ((state == DRAIN) && accept);
            if (start_ok) begin
                ptr       <= base;
                remaining <= count;
            end else if (capture) begin
                remaining <= remaining - CW'(1);
                if (!last_capture) begin
                    ptr <= ptr + AW'(1);
                end
            end
        end
    end

    msr_out_stage #(
        .DW (DW)
    ) u_out_stage (
        .clock     (clock),
        .reset     (reset),
        .load_en   (state == RUN),
        .load_data (mem_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .capture   (capture),
        .accept    (accept)
    );

`ifdef MSR_CHECKSUM_EN
    // Running sum of words the sink has taken; cleared by each accepted
    // start and otherwise held, so it is final while done is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule
